// File: rtl/lc3b_icache.sv
// Direct-mapped read-only instruction cache for the LC-3b fetch stage.
// Zero-wait hits, single-beat 128-bit line refill from physical memory.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_IDLE | lookups enabled; a miss latches the line address
//   ST_FILL | pmem_read held with the latched address until pmem_resp
//   ST_WAIT | one quiet cycle so memory can drop resp; retry hits next
module lc3b_icache #(
  parameter int NUM_SETS = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [15:0]  icache_address,
  input  logic         icache_read,
  output logic [15:0]  icache_rdata,
  output logic         icache_resp,
  input  logic         flush,
  output logic [15:0]  pmem_address,
  output logic         pmem_read,
  input  logic [127:0] pmem_rdata,
  input  logic         pmem_resp,
  output logic [15:0]  hit_count,
  output logic [15:0]  miss_count
);

  localparam int IDX   = $clog2(NUM_SETS);
  localparam int TAG_W = 12 - IDX;

  typedef enum logic [1:0] {ST_IDLE, ST_FILL, ST_WAIT} state_t;

  state_t                state_q, state_d;
  logic [15:0]           fill_addr_q, fill_addr_d;
  logic                  flush_seen_q, flush_seen_d;
  logic [NUM_SETS-1:0]   valid_q, valid_d;
  logic [15:0]           hit_count_q, hit_count_d;
  logic [15:0]           miss_count_q, miss_count_d;

  logic [TAG_W-1:0]      tag_q  [NUM_SETS];
  logic [127:0]          data_q [NUM_SETS];

  logic [IDX-1:0]        req_idx;
  logic [TAG_W-1:0]      req_tag;
  logic [2:0]            req_off;
  logic [IDX-1:0]        fill_idx;
  logic [TAG_W-1:0]      fill_tag;
  logic                  hit;
  logic                  resp;
  logic                  fill_we;
  logic                  unused_addr_bit;

  assign req_off         = icache_address[3:1];
  assign req_idx         = icache_address[4+IDX-1:4];
  assign req_tag         = icache_address[15:4+IDX];
  assign fill_idx        = fill_addr_q[4+IDX-1:4];
  assign fill_tag        = fill_addr_q[15:4+IDX];
  assign unused_addr_bit = icache_address[0];

  assign hit     = icache_read && (state_q == ST_IDLE) && valid_q[req_idx] &&
                   (tag_q[req_idx] == req_tag);
  assign resp    = hit && !flush;
  assign fill_we = (state_q == ST_FILL) && pmem_resp;

  assign icache_resp  = resp;
  assign icache_rdata = data_q[req_idx][{req_off, 4'b0000} +: 16];
  assign pmem_read    = (state_q == ST_FILL);
  assign pmem_address = fill_addr_q;
  assign hit_count    = hit_count_q;
  assign miss_count   = miss_count_q;

  always_comb begin
    state_d      = state_q;
    fill_addr_d  = fill_addr_q;
    flush_seen_d = flush_seen_q;
    valid_d      = valid_q;
    hit_count_d  = hit_count_q + {15'd0, resp};
    miss_count_d = miss_count_q;

    case (state_q)
      ST_IDLE: begin
        if (icache_read && !hit && !flush) begin
          fill_addr_d  = {icache_address[15:4], 4'b0000};
          flush_seen_d = 1'b0;
          miss_count_d = miss_count_q + 16'd1;
          state_d      = ST_FILL;
        end
      end
      ST_FILL: begin
        if (flush) flush_seen_d = 1'b1;
        if (pmem_resp) state_d = ST_WAIT;
      end
      ST_WAIT: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (flush) valid_d = '0;
    // A flush seen at any point in the fill leaves the arriving line invalid.
    if (fill_we) valid_d[fill_idx] = !(flush || flush_seen_q);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      fill_addr_q  <= 16'h0000;
      flush_seen_q <= 1'b0;
      valid_q      <= '0;
      hit_count_q  <= 16'h0000;
      miss_count_q <= 16'h0000;
    end else begin
      state_q      <= state_d;
      fill_addr_q  <= fill_addr_d;
      flush_seen_q <= flush_seen_d;
      valid_q      <= valid_d;
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && fill_we) begin
      tag_q[fill_idx]  <= fill_tag;
      data_q[fill_idx] <= pmem_rdata;
    end
  end

endmodule

// File: tb/tb_lc3b_icache.sv
// Directed bench for lc3b_icache: per-cycle vector table for fills/hits/eviction,
// hand sequences for redirect, flush and reset during a fill.
module tb_lc3b_icache;

  logic         clk;
  logic         rst_n;
  logic [15:0]  icache_address;
  logic         icache_read;
  logic [15:0]  icache_rdata;
  logic         icache_resp;
  logic         flush;
  logic [15:0]  pmem_address;
  logic         pmem_read;
  logic [127:0] pmem_rdata;
  logic         pmem_resp;
  logic [15:0]  hit_count;
  logic [15:0]  miss_count;

  int n_checks = 0;
  int n_fail   = 0;
  int mem_cnt  = 0;
  logic force_resp = 1'b0;

  lc3b_icache #(.NUM_SETS(8)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .icache_address (icache_address),
    .icache_read    (icache_read),
    .icache_rdata   (icache_rdata),
    .icache_resp    (icache_resp),
    .flush          (flush),
    .pmem_address   (pmem_address),
    .pmem_read      (pmem_read),
    .pmem_rdata     (pmem_rdata),
    .pmem_resp      (pmem_resp),
    .hit_count      (hit_count),
    .miss_count     (miss_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rd;
    logic [15:0] addr;
    logic        fl;
    logic        e_resp;
    logic [15:0] e_data;
    logic        e_pread;
    logic [15:0] e_paddr;
    logic [15:0] e_hit;
    logic [15:0] e_miss;
  } vec_t;

  vec_t vecs[$];

  // Memory image: word w of the line at base is (base ^ 0x0100) | w.
  function automatic logic [127:0] mem_line(input logic [15:0] base);
    logic [127:0] l;
    l = '0;
    for (int w = 0; w < 8; w++) l[w*16 +: 16] = (base ^ 16'h0100) | 16'(w);
    return l;
  endfunction

  task automatic add(input logic rd, input logic [15:0] addr, input logic fl,
                     input logic e_resp, input logic [15:0] e_data,
                     input logic e_pread, input logic [15:0] e_paddr,
                     input logic [15:0] e_hit, input logic [15:0] e_miss);
    vec_t v;
    v.rd = rd; v.addr = addr; v.fl = fl; v.e_resp = e_resp; v.e_data = e_data;
    v.e_pread = e_pread; v.e_paddr = e_paddr; v.e_hit = e_hit; v.e_miss = e_miss;
    vecs.push_back(v);
  endtask

  task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // One cycle: memory model responds 3 cycles into a fill, then inputs are applied.
  task automatic cyc(input logic rd, input logic [15:0] addr, input logic fl);
    @(posedge clk);
    #1;
    if (pmem_read) begin
      mem_cnt++;
      pmem_resp  = (mem_cnt == 3);
      pmem_rdata = mem_line(pmem_address);
    end else begin
      mem_cnt    = 0;
      pmem_resp  = force_resp;
      pmem_rdata = mem_line(16'h0000);
    end
    icache_read    = rd;
    icache_address = addr;
    flush          = fl;
    #1;
  endtask

  task automatic wait_hit(input logic [15:0] addr, input logic [15:0] exp_data,
                          input int exp_n, input string nm);
    int n;
    n = 0;
    do begin
      cyc(1'b1, addr, 1'b0);
      n++;
    end while (!icache_resp && n < 10);
    check({nm, " resp"}, {15'd0, icache_resp}, 16'd1);
    check({nm, " data"}, icache_rdata, exp_data);
    check({nm, " cycles"}, 16'(n), 16'(exp_n));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; icache_read = 1'b0; icache_address = 16'h0000; flush = 1'b0;
    pmem_resp = 1'b0; pmem_rdata = '0;

    // Cold miss on 0x0102 with 3-cycle memory.
    add(1, 16'h0102, 0, 0, 16'h0000, 0, 16'h0000, 0, 0);
    for (int k = 0; k < 3; k++) add(1, 16'h0102, 0, 0, 16'h0000, 1, 16'h0100, 0, 1);
    add(1, 16'h0102, 0, 0, 16'h0000, 0, 16'h0000, 0, 1);
    add(1, 16'h0102, 0, 1, 16'h0001, 0, 16'h0000, 0, 1);
    // Spatial hits across the line.
    for (int i = 0; i < 8; i++)
      add(1, 16'h0100 + 16'(2*i), 0, 1, 16'(i), 0, 16'h0000, 16'(1+i), 1);
    // Conflict eviction in set 0.
    add(1, 16'h0180, 0, 0, 16'h0000, 0, 16'h0000, 9, 1);
    for (int k = 0; k < 3; k++) add(1, 16'h0180, 0, 0, 16'h0000, 1, 16'h0180, 9, 2);
    add(1, 16'h0180, 0, 0, 16'h0000, 0, 16'h0000, 9, 2);
    add(1, 16'h0180, 0, 1, 16'h0080, 0, 16'h0000, 9, 2);
    add(1, 16'h0100, 0, 0, 16'h0000, 0, 16'h0000, 10, 2);
    for (int k = 0; k < 3; k++) add(1, 16'h0100, 0, 0, 16'h0000, 1, 16'h0100, 10, 3);
    add(1, 16'h0100, 0, 0, 16'h0000, 0, 16'h0000, 10, 3);
    add(1, 16'h0100, 0, 1, 16'h0000, 0, 16'h0000, 10, 3);
    // Idle: counters frozen.
    add(0, 16'h0000, 0, 0, 16'h0000, 0, 16'h0000, 11, 3);
    add(0, 16'h0000, 0, 0, 16'h0000, 0, 16'h0000, 11, 3);

    repeat (2) @(posedge clk);
    #2;
    check("rst resp",  {15'd0, icache_resp}, 16'd0);
    check("rst pread", {15'd0, pmem_read}, 16'd0);
    check("rst paddr", pmem_address, 16'h0000);
    check("rst hits",  hit_count, 16'd0);
    check("rst miss",  miss_count, 16'd0);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      cyc(vecs[i].rd, vecs[i].addr, vecs[i].fl);
      check($sformatf("vec%0d resp", i), {15'd0, icache_resp}, {15'd0, vecs[i].e_resp});
      if (vecs[i].e_resp) check($sformatf("vec%0d rdata", i), icache_rdata, vecs[i].e_data);
      check($sformatf("vec%0d pread", i), {15'd0, pmem_read}, {15'd0, vecs[i].e_pread});
      if (vecs[i].e_pread) check($sformatf("vec%0d paddr", i), pmem_address, vecs[i].e_paddr);
      check($sformatf("vec%0d hits", i), hit_count, vecs[i].e_hit);
      check($sformatf("vec%0d miss", i), miss_count, vecs[i].e_miss);
    end

    // Redirect mid-fill: fill of 0x0200 completes, then 0x0300 misses.
    cyc(1, 16'h0200, 0);
    check("redir miss resp", {15'd0, icache_resp}, 16'd0);
    for (int k = 0; k < 3; k++) begin
      cyc(1, 16'h0300, 0);
      check("redir pread", {15'd0, pmem_read}, 16'd1);
      check("redir paddr", pmem_address, 16'h0200);
      check("redir fill resp", {15'd0, icache_resp}, 16'd0);
    end
    cyc(1, 16'h0300, 0);
    check("redir wait pread", {15'd0, pmem_read}, 16'd0);
    check("redir wait resp", {15'd0, icache_resp}, 16'd0);
    cyc(1, 16'h0300, 0);
    check("redir 2nd miss resp", {15'd0, icache_resp}, 16'd0);
    cyc(1, 16'h0300, 0);
    check("redir 2nd pread", {15'd0, pmem_read}, 16'd1);
    check("redir 2nd paddr", pmem_address, 16'h0300);
    wait_hit(16'h0300, 16'h0200, 4, "redir hit");

    // Flush in IDLE, then the line misses.
    cyc(0, 16'h0000, 1);
    cyc(1, 16'h0300, 0);
    check("flush miss resp", {15'd0, icache_resp}, 16'd0);
    cyc(1, 16'h0300, 0);
    check("flush miss pread", {15'd0, pmem_read}, 16'd1);
    wait_hit(16'h0300, 16'h0200, 4, "flush refill");
    // Flush coincident with a hit: no resp.
    cyc(1, 16'h0300, 1);
    check("flush+hit resp", {15'd0, icache_resp}, 16'd0);
    cyc(1, 16'h0300, 0);
    check("post flush miss", {15'd0, icache_resp}, 16'd0);
    cyc(1, 16'h0300, 0);
    check("ffill pread", {15'd0, pmem_read}, 16'd1);
    // Flush during FILL leaves the arriving line invalid.
    cyc(1, 16'h0300, 1);
    cyc(1, 16'h0300, 0);
    cyc(1, 16'h0300, 0);
    check("ffill wait pread", {15'd0, pmem_read}, 16'd0);
    cyc(1, 16'h0300, 0);
    check("ffill retry resp", {15'd0, icache_resp}, 16'd0);
    cyc(1, 16'h0300, 0);
    check("ffill retry pread", {15'd0, pmem_read}, 16'd1);
    wait_hit(16'h0300, 16'h0200, 4, "ffill refill");

    // Reset during a fill of 0x0110; a late pmem_resp follows.
    cyc(1, 16'h0110, 0);
    cyc(1, 16'h0110, 0);
    check("rfill pread", {15'd0, pmem_read}, 16'd1);
    check("rfill paddr", pmem_address, 16'h0110);
    rst_n = 1'b0;
    cyc(0, 16'h0000, 0);
    check("rfill after rst pread", {15'd0, pmem_read}, 16'd0);
    check("rfill after rst paddr", pmem_address, 16'h0000);
    check("rfill after rst hits", hit_count, 16'd0);
    check("rfill after rst miss", miss_count, 16'd0);
    rst_n = 1'b1;
    force_resp = 1'b1;
    cyc(0, 16'h0000, 0);
    force_resp = 1'b0;
    check("late resp pread", {15'd0, pmem_read}, 16'd0);
    cyc(1, 16'h0300, 0);
    check("rst cleared valid resp", {15'd0, icache_resp}, 16'd0);
    cyc(1, 16'h0300, 0);
    check("rst cleared valid pread", {15'd0, pmem_read}, 16'd1);
    check("rst cleared valid paddr", pmem_address, 16'h0300);
    wait_hit(16'h0300, 16'h0200, 4, "post rst hit");
    cyc(1, 16'h0110, 0);
    check("late resp ignored", {15'd0, icache_resp}, 16'd0);
    cyc(1, 16'h0110, 0);
    check("0110 pread", {15'd0, pmem_read}, 16'd1);
    check("0110 paddr", pmem_address, 16'h0110);
    wait_hit(16'h0110, 16'h0010, 4, "0110 hit");
    cyc(0, 16'h0000, 0);
    check("final hits", hit_count, 16'd2);
    check("final miss", miss_count, 16'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
